// File: rtl/wb_trace_writer.sv
// -----------------------------------------------------------------------------
// wb_trace_writer
// Producer side of the commit-trace channel for the dual-issue core.
// Captures both writeback channels every cycle and keeps only architectural
// register writes. Records are queued in program order (channel 0 ahead of
// channel 1) and presented one {pc, rd, wdata} record per valid/ready
// handshake to the trace sink.
//
// Ports
//   clk, resetn            core clock, asynchronous active-low reset
//   trace_en               capture enable (buffered records still drain)
//   wbN_en/rd/wdata/pc     writeback channel N (N = 0, 1)
//   trace_valid/ready      head-record handshake to the sink
//   trace_pc/rd/wdata      head record contents
//   stall_req              WB must hold off new commits
//   overflow               sticky: a qualifying record was dropped
//   rec_count              number of records emitted (wraps at 2^32)
// -----------------------------------------------------------------------------
module wb_trace_writer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] SKIP_BASE = 32'hbfc00380,
    parameter logic [31:0] SKIP_MASK = 32'hfffffff8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trace_en,
    input  logic        wb0_en,
    input  logic [4:0]  wb0_rd,
    input  logic [31:0] wb0_wdata,
    input  logic [31:0] wb0_pc,
    input  logic        wb1_en,
    input  logic [4:0]  wb1_rd,
    input  logic [31:0] wb1_wdata,
    input  logic [31:0] wb1_pc,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_rd,
    output logic [31:0] trace_wdata,
    output logic        stall_req,
    output logic        overflow,
    output logic [31:0] rec_count
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_STALL = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] C_ONE   = (AW+1)'(1);
    localparam logic [AW:0] C_TWO   = (AW+1)'(2);

    logic [31:0]   r_pc    [DEPTH];
    logic [4:0]    r_rd    [DEPTH];
    logic [31:0]   r_wdata [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [31:0]   r_rec_count;

    logic          w_ch0_q;
    logic          w_ch1_q;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_drop;
    logic          w_pop;
    logic [AW:0]   w_free;
    logic [AW:0]   w_push_n;
    logic [AW-1:0] w_slot1;

    // Qualification, space check and push/pop decode for this cycle.
    always_comb begin
        w_ch0_q  = trace_en & wb0_en & (wb0_rd != 5'd0) &
                   ((wb0_pc & SKIP_MASK) != SKIP_BASE);
        w_ch1_q  = trace_en & wb1_en & (wb1_rd != 5'd0) &
                   ((wb1_pc & SKIP_MASK) != SKIP_BASE);
        // Space comes only from the registered count; a same-cycle pop
        // deliberately does not free a slot for a push.
        w_free   = C_DEPTH - r_count;
        w_acc0   = w_ch0_q & (w_free >= C_ONE);
        if (w_ch0_q) begin
            w_acc1 = w_ch1_q & (w_free >= C_TWO);
        end else begin
            w_acc1 = w_ch1_q & (w_free >= C_ONE);
        end
        w_drop   = (w_ch0_q & ~w_acc0) | (w_ch1_q & ~w_acc1);
        w_push_n = (AW+1)'(w_acc0) + (AW+1)'(w_acc1);
        // Channel 1 lands right after channel 0 when both are stored.
        w_slot1  = r_tail + AW'(w_acc0);
        w_pop    = (r_count != '0) & trace_ready;
    end

    // FIFO storage: cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= 32'd0;
                r_rd[i]    <= 5'd0;
                r_wdata[i] <= 32'd0;
            end
        end else begin
            if (w_acc0) begin
                r_pc[r_tail]    <= wb0_pc;
                r_rd[r_tail]    <= wb0_rd;
                r_wdata[r_tail] <= wb0_wdata;
            end
            if (w_acc1) begin
                r_pc[w_slot1]    <= wb1_pc;
                r_rd[w_slot1]    <= wb1_rd;
                r_wdata[w_slot1] <= wb1_wdata;
            end
        end
    end

    // Pointers, occupancy, sticky overflow and emitted-record counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_rec_count <= 32'd0;
        end else begin
            r_tail  <= r_tail + AW'(w_push_n);
            r_count <= r_count + w_push_n - (AW+1)'(w_pop);
            if (w_pop) begin
                r_head      <= r_head + AW'(1);
                r_rec_count <= r_rec_count + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid = (r_count != '0);
    assign trace_pc    = r_pc[r_head];
    assign trace_rd    = r_rd[r_head];
    assign trace_wdata = r_wdata[r_head];
    assign stall_req   = (r_count >= C_STALL);
    assign overflow    = r_overflow;
    assign rec_count   = r_rec_count;

endmodule
